// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch-and-issue front end for the single-issue MIPS core. Holds the PC, fetches one
//   32-bit word per request over a req/ack memory handshake, then presents it downstream
//   with a valid/ready handshake. The next PC is chosen when the issue handshake completes:
//   sequential (PC+4) or the beq target when the decoded Branch flag and ALU Zero are set.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned).
//   CNT_W     width of the retired-instruction counter.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   imem_req/addr   fetch request and word address (FETCH state only)
//   imem_ack/rdata  memory response; rdata valid when ack is high
//   Instruction     registered instruction being issued (Instruction_op = bits [31:26])
//   instr_pc        PC of the issued instruction
//   instr_valid     instruction is valid and held stable
//   instr_ready     downstream accepts the instruction this cycle
//   Branch, Zero    control/ALU flags for the current instruction, sampled on handshake only
//   instr_count     number of issue handshakes since reset (wraps)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      Instruction,
  output logic [5:0]       Instruction_op,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             Branch,
  input  logic             Zero,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  state_e             r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr;
  logic [31:0]        r_instr_pc;
  logic               r_req;
  logic               r_valid;
  logic [CNT_W-1:0]   r_count;

  logic [31:0]        w_offset;
  logic [31:0]        w_pc_seq;
  logic [31:0]        w_pc_target;
  logic [31:0]        w_next_pc;

  // beq target: sign-extended 16-bit word offset relative to the following instruction.
  // All additions are 32-bit and wrap naturally.
  assign w_offset    = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_pc_seq    = r_instr_pc + 32'd4;
  assign w_pc_target = w_pc_seq + w_offset;
  assign w_next_pc   = (Branch && Zero) ? w_pc_target : w_pc_seq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0000;
      r_instr_pc <= 32'h0000_0000;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_state <= StFetch;
          r_req   <= 1'b1;
        end
        StFetch: begin
          if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= StIssue;
            r_req      <= 1'b0;
            r_valid    <= 1'b1;
          end
        end
        StIssue: begin
          // r_valid is high throughout ISSUE, so ready alone completes the handshake.
          if (instr_ready) begin
            r_count <= r_count + CNT_W'(1);
            r_pc    <= w_next_pc;
            r_state <= StFetch;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req       = r_req;
  assign imem_addr      = r_pc;
  assign Instruction    = r_instr;
  assign Instruction_op = r_instr[31:26];
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_valid;
  assign instr_count    = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        ack_en = 1'b0;
  logic        ack_force = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic        req, ack, valid;
  logic [31:0] addr, instr, ipc;
  logic [5:0]  op;
  logic [31:0] count;

  logic        req2, ack2, valid2;
  logic [31:0] addr2, instr2, ipc2;
  logic [5:0]  op2;
  logic [31:0] count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Combinational memory: answers a request when enabled; ack_force injects stray acks.
  assign ack  = (req & ack_en) | ack_force;
  assign ack2 = (req2 & ack_en) | ack_force;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .imem_req(req), .imem_addr(addr), .imem_ack(ack),
    .imem_rdata(rdata), .Instruction(instr), .Instruction_op(op), .instr_pc(ipc),
    .instr_valid(valid), .instr_ready(ready), .Branch(branch), .Zero(zero),
    .instr_count(count)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata), .Instruction(instr2), .Instruction_op(op2), .instr_pc(ipc2),
    .instr_valid(valid2), .instr_ready(ready), .Branch(branch), .Zero(zero),
    .instr_count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both DUTs in FETCH at their reset PC.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Issues four non-branch instructions so the DUT is fetching at 0x10.
  task automatic advance_to_10();
    ready = 1'b1; branch = 1'b0; zero = 1'b0; rdata = 32'h0; ack_en = 1'b1; ack_force = 1'b0;
    do_reset();
    repeat (4) begin
      tick();
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_en = 1'b1; ready = 1'b1; rdata = 32'h0;
    tick();
    tick();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", req); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (op !== 6'b000000) begin errors++; $display("FAIL reset_op got %b exp 0", op); end
    checks++; if (ipc !== 32'h0) begin errors++; $display("FAIL reset_ipc got %h exp 0", ipc); end
    checks++; if (count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr2 got %h exp fffffffc", addr2); end
    rst = 1'b0;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL first_cycle_req got %b exp 0", req); end
    tick();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL second_cycle_req got %b exp 1", req); end
  endtask

  task automatic test_zero_wait();
    ack_en = 1'b1; ready = 1'b1; rdata = 32'h0; branch = 1'b0; zero = 1'b0;
    do_reset();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL zw_addr0 got %h exp 0", addr); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (valid !== 1'b1 || ipc !== 32'(4 * (k - 1))) begin
        errors++; $display("FAIL zw_issue%0d got valid %b pc %h exp 1 %h", k, valid, ipc, 4 * (k - 1));
      end
      tick();
      checks++; if (req !== 1'b1 || addr !== 32'(4 * k)) begin
        errors++; $display("FAIL zw_fetch%0d got req %b addr %h exp 1 %h", k, req, addr, 4 * k);
      end
    end
    checks++; if (count !== 32'd3) begin errors++; $display("FAIL zw_count got %0d exp 3", count); end
  endtask

  task automatic test_ack_delay();
    ack_en = 1'b1; ready = 1'b1; rdata = 32'h0;
    do_reset();
    tick();
    ack_en = 1'b0;
    tick();
    rdata = 32'h2002_0005;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (req !== 1'b1 || addr !== 32'h4 || instr !== 32'h0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL delay_hold%0d got req %b addr %h instr %h exp 1 4 0", c, req, addr, instr);
      end
      if (c == 4) ack_en = 1'b1;
      else tick();
    end
    tick();
    checks++; if (instr !== 32'h2002_0005 || ipc !== 32'h4 || valid !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL delay_load got instr %h pc %h exp 20020005 4", instr, ipc);
    end
  endtask

  task automatic test_backpressure();
    ack_en = 1'b1; ready = 1'b0; rdata = 32'h8C01_0004;
    do_reset();
    tick();
    ack_force = 1'b1; rdata = 32'hFFFF_FFFF;
    repeat (5) begin
      tick();
      checks++;
      if (valid !== 1'b1 || op !== 6'b100011 || instr !== 32'h8C01_0004 || req !== 1'b0 ||
          count !== 32'd0) begin
        errors++;
        $display("FAIL bp_hold got valid %b op %b instr %h req %b count %0d", valid, op, instr,
                 req, count);
      end
    end
    ack_force = 1'b0; ready = 1'b1;
    tick();
    checks++; if (count !== 32'd1 || addr !== 32'h4 || valid !== 1'b0 || req !== 1'b1) begin
      errors++; $display("FAIL bp_release got count %0d addr %h exp 1 4", count, addr);
    end
  endtask

  task automatic test_branch();
    advance_to_10();
    checks++; if (addr !== 32'h10) begin errors++; $display("FAIL br_setup got %h exp 10", addr); end
    rdata = 32'h1000_FFFE;
    tick();
    branch = 1'b1; zero = 1'b1;
    tick();
    checks++; if (addr !== 32'h0C) begin errors++; $display("FAIL br_taken got %h exp 0c", addr); end
    branch = 1'b0; zero = 1'b0; rdata = 32'h0;
    tick();
    tick();
    rdata = 32'h1000_FFFE;
    tick();
    branch = 1'b1; zero = 1'b0;
    tick();
    checks++; if (addr !== 32'h14) begin errors++; $display("FAIL br_not_taken got %h exp 14", addr); end
    branch = 1'b0;
  endtask

  task automatic test_sample_at_handshake();
    advance_to_10();
    rdata = 32'h1000_FFFE; ready = 1'b0;
    tick();
    branch = 1'b1; zero = 1'b1;
    tick();
    checks++; if (valid !== 1'b1 || count !== 32'd4) begin
      errors++; $display("FAIL hs_hold got valid %b count %0d exp 1 4", valid, count);
    end
    zero = 1'b0; ready = 1'b1;
    tick();
    checks++; if (addr !== 32'h14) begin errors++; $display("FAIL hs_sample got %h exp 14", addr); end
    branch = 1'b0;
  endtask

  task automatic test_wrap();
    ready = 1'b1; rdata = 32'h0; branch = 1'b0; zero = 1'b0; ack_en = 1'b1;
    do_reset();
    checks++; if (addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_start got %h exp fffffffc", addr2); end
    tick();
    checks++; if (ipc2 !== 32'hFFFF_FFFC || valid2 !== 1'b1) begin
      errors++; $display("FAIL wrap_issue got pc %h valid %b", ipc2, valid2);
    end
    tick();
    checks++; if (addr2 !== 32'h0 || req2 !== 1'b1) begin errors++; $display("FAIL wrap_next got %h exp 0", addr2); end
  endtask

  task automatic test_reset_mid_issue();
    ready = 1'b1; rdata = 32'h0; ack_en = 1'b1;
    do_reset();
    tick();
    tick();
    ready = 1'b0;
    tick();
    checks++; if (valid !== 1'b1 || count !== 32'd1 || ipc !== 32'h4) begin
      errors++; $display("FAIL rmi_setup got valid %b count %0d pc %h", valid, count, ipc);
    end
    rst = 1'b1; ready = 1'b1;
    tick();
    checks++; if (valid !== 1'b0 || count !== 32'd0 || req !== 1'b0) begin
      errors++; $display("FAIL rmi_reset got valid %b count %0d req %b exp 0 0 0", valid, count, req);
    end
    rst = 1'b0;
    tick();
    checks++; if (req !== 1'b1 || addr !== 32'h0 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL rmi_restart got req %b addr %h addr2 %h", req, addr, addr2);
    end
  endtask

  task automatic test_reset_mid_fetch();
    ready = 1'b1; rdata = 32'h0; ack_en = 1'b0;
    do_reset();
    rst = 1'b1; rdata = 32'hABCD_1234; ack_force = 1'b1;
    tick();
    checks++; if (req !== 1'b0 || instr !== 32'h0 || valid !== 1'b0) begin
      errors++; $display("FAIL rmf_reset got req %b instr %h valid %b exp 0 0 0", req, instr, valid);
    end
    tick();
    checks++; if (valid !== 1'b0 || instr !== 32'h0) begin
      errors++; $display("FAIL rmf_ignore got valid %b instr %h exp 0 0", valid, instr);
    end
    ack_force = 1'b0; rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_ack_delay();
    test_backpressure();
    test_branch();
    test_sample_at_handshake();
    test_wrap();
    test_reset_mid_issue();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-and-issue front end for the single-issue MIPS core.
- Holds the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and presents each word to the control unit and datapath with a valid/ready handshake.
- Closes the control loop: consumes the decoded Branch flag and the ALU Zero flag to select the next PC (sequential or beq target).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- imem_req  output  1  fetch request; high only in FETCH state.
- imem_addr  output  32  fetch address (= PC); bits [1:0] always 0.
- imem_ack  input  1  memory returns data on imem_rdata this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- Instruction  output  32  registered instruction being issued.
- Instruction_op  output  6  Instruction[31:26]; drives control unit opcode input.
- instr_pc  output  32  PC of the issued instruction.
- instr_valid  output  1  Instruction is valid and held stable.
- instr_ready  input  1  downstream accepts the instruction this cycle.
- Branch  input  1  decoded branch flag for the current Instruction (combinational from control unit).
- Zero  input  1  ALU zero flag for the current Instruction.
- instr_count  output  CNT_W  number of issue handshakes since reset.

Behaviour:
- Reset (rst=1 at a clk edge): PC=RESET_PC; state=IDLE; imem_req=0; Instruction=0 (so Instruction_op=6'b000000); instr_pc=0; instr_valid=0; instr_count=0. Reset overrides all other activity in the same cycle.
- States: IDLE, FETCH, ISSUE.
  - IDLE -> FETCH unconditionally after one cycle. First imem_req is seen in the 2nd cycle after rst deasserts.
  - FETCH: imem_req=1, imem_addr=PC, both held stable until ack.
    - imem_ack=1 (zero-wait allowed, same cycle as req): Instruction<=imem_rdata, instr_pc<=PC, state<=ISSUE.
    - imem_ack=0: remain in FETCH.
  - ISSUE: instr_valid=1; Instruction and instr_pc held stable; imem_req=0.
    - Handshake (instr_valid & instr_ready): instr_count += 1 (wraps modulo 2^CNT_W); state<=FETCH.
    - Next-PC selected on handshake:
      - Branch & Zero: PC <= instr_pc + 4 + (sign_extend(Instruction[15:0]) << 2).
      - Otherwise: PC <= instr_pc + 4.
    - Branch and Zero are sampled only on the handshake cycle; their values are ignored in all other cycles and states.
    - instr_ready=0: hold indefinitely with no side effects.
- Arithmetic: all PC math is 32-bit unsigned, modulo 2^32. 0xFFFFFFFC + 4 = 0x00000000; negative offsets wrap likewise.
- imem_ack outside FETCH is ignored; no capture, no state change.
- Throughput: at most one instruction per 2 cycles (FETCH + ISSUE) with zero-wait memory and ready held high.
- Instruction_op is a pure slice of the Instruction register and changes only when Instruction is loaded.
- Reset mid-FETCH: imem_req drops the cycle after the reset edge; an ack arriving during reset is ignored.
- Reset mid-ISSUE: instr_valid drops; no count increment; no PC update.

Test Plan:
- Reset, then zero-wait memory (ack tied to req, rdata=32'h0000_0000), ready=1 -> imem_req first high 2 cycles after rst deasserts; addresses 0x0, 0x4, 0x8 on successive requests; instr_count=3 after the third handshake.
- Ack delayed 3 cycles at addr 0x4 -> imem_req and imem_addr=0x4 stable for 4 cycles; Instruction loads only on the ack cycle.
- Backpressure: ready=0 for 5 cycles while holding lw word 32'h8C01_0004 -> instr_valid stays 1; Instruction_op=6'b100011 stable; no new imem_req; instr_count unchanged until ready=1.
- beq at PC 0x10, word 32'h1000_FFFE, Branch=1, Zero=1 -> next fetch address 0x10 + 4 - 8 = 0x0C. Same word with Zero=0 -> next fetch address 0x14.
- Branch=1, Zero=1 held during a cycle with ready=0, then Zero=0 on the handshake cycle -> next PC is 0x14 (values sampled only at handshake).
- RESET_PC=32'hFFFF_FFFC, non-branch word issued -> next fetch address 0x00000000. rst asserted during a pending ISSUE -> instr_valid=0 next cycle; instr_count=0; PC restarts at RESET_PC.
